data_mem_mmio: RTL and testbench
================================

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 Parameter WIDTH, default 32, data and address width.
REQ-002 Parameter DEPTH, default 64, RAM size in words; power of two.
REQ-003 Parameter FIFO_DEPTH, default 4, output FIFO entries; power of two.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port memWriteM  input  1  store strobe from the core memory stage.
REQ-007 Port aluResultM  input  WIDTH  byte address from the core memory stage.
REQ-008 Port writeData  input  WIDTH  store data.
REQ-009 Port readDataM  output  WIDTH  load data returned to the core in the same cycle.
REQ-010 Port outData  output  WIDTH  FIFO head word to the external sink.
REQ-011 Port outValid  output  1  FIFO holds at least one word.
REQ-012 Port outReady  input  1  external sink accepts outData this cycle.

Function
REQ-013 Address decode: aluResultM[31:16]==16'hFFFF selects MMIO; any other address selects RAM; bits [1:0] ignored everywhere.
REQ-014 RAM index = aluResultM[log2(DEPTH)+1:2]; upper address bits aliased.
REQ-015 RAM read is combinational: readDataM = RAM[index] while RAM is selected.
REQ-016 RAM write is synchronous: memWriteM=1 with RAM selected writes writeData at the clock edge.
REQ-017 A read of an address written in the same cycle returns the old word; the new word is visible from the next cycle.
REQ-018 MMIO offsets use aluResultM[15:0]: 0x0000 CYCLE, 0x0004 STATUS, 0x0008 TXDATA, 0x000C CTRL.
REQ-019 Unmapped MMIO offsets read 0; writes to them are ignored.
REQ-020 CYCLE: 32-bit counter; increments by 1 every cycle; wraps 0xFFFF_FFFF -> 0.
REQ-021 A write to CYCLE loads 0 on that edge, overriding the increment; write data ignored; a read returns the registered value.
REQ-022 STATUS read-only: bit0 empty, bit1 full, bit2 overflow (sticky), bits[log2(FIFO_DEPTH)+3:3] occupancy count, remaining bits 0.
REQ-023 A write to TXDATA pushes writeData into the FIFO; a TXDATA read returns 0.
REQ-024 A write to CTRL with writeData[0]=1 clears overflow; CTRL reads 0.
REQ-025 FIFO pop occurs when outValid && outReady; outData = head entry; outValid = !empty.
REQ-026 No fall-through: a word pushed into an empty FIFO appears on outValid/outData from the next cycle.
REQ-027 Push with FIFO full and no pop in the same cycle: word dropped, contents unchanged, overflow set to 1.
REQ-028 Push and pop in the same cycle when full: both occur, count unchanged, overflow unchanged.
REQ-029 Push and pop in the same cycle with 0 < count < FIFO_DEPTH: both occur, count unchanged.
REQ-030 If the CTRL clear and an overflowing push fall on the same edge, set wins; this cannot occur with a single write port and needs no extra logic.
REQ-031 outData is don't-care when outValid=0; the bench does not check it.
REQ-032 Read and write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Reset
REQ-033 reset=1 asynchronously forces CYCLE=0, FIFO pointers and count=0, overflow=0, and outValid=0.
REQ-034 RAM contents are not reset and are preserved across reset.
REQ-035 Reset asserted mid-operation discards all FIFO contents; a push on the reset edge is lost.
REQ-036 After reset deasserts, CYCLE reads 0 at the first clock edge and increments from there.

Verification
REQ-037 Store 0xDEAD_BEEF at 0x0000_0010, then load 0x0000_0010 and 0x0000_0013 -> both return 0xDEAD_BEEF; address 0x0000_0110 (aliased, DEPTH=64) also returns it.
REQ-038 Release reset, wait 10 cycles, read 0xFFFF_0000 -> 10; write CYCLE -> next-cycle read 0; force the counter to 0xFFFF_FFFF -> next read 0.
REQ-039 outReady=0; push 1,2,3,4 -> STATUS=0x22 (full, count 4); push 5 -> STATUS bit2=1, word dropped; outReady=1 -> outData sequence 1,2,3,4, then outValid=0.
REQ-040 FIFO full with outReady=1; push 9 in the same cycle as the pop -> overflow stays 0; 9 is drained last.
REQ-041 Overflow set; write CTRL=1 -> STATUS bit2=0; write CTRL=0 -> no change.
REQ-042 Push 2 words, assert reset for 1 cycle -> outValid=0, STATUS=0x01; RAM word stored before reset is still readable.

Source files
------------

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: word RAM with an MMIO window (cycle counter, status,
// TX FIFO, control) for the core memory stage.
// Ports: clk, reset (async, active-high); memWriteM, aluResultM and
// writeData from the core; readDataM is the combinational load result;
// outData/outValid/outReady drain the TX FIFO to an external sink.
module data_mem_mmio #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memWriteM,
  input  logic [WIDTH-1:0] aluResultM,
  input  logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] readDataM,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);

  localparam logic [13:0] OFF_CYCLE  = 14'd0;
  localparam logic [13:0] OFF_STATUS = 14'd1;
  localparam logic [13:0] OFF_TX     = 14'd2;
  localparam logic [13:0] OFF_CTRL   = 14'd3;

  logic          mmio_sel;
  logic [AW-1:0] ram_idx;
  logic [13:0]   off;
  logic          wr_ram;
  logic          wr_cycle;
  logic          wr_tx;
  logic          wr_ctrl;
  logic          unused_addr;

  assign mmio_sel = (aluResultM[31:16] == 16'hFFFF);
  assign ram_idx  = aluResultM[AW+1:2];
  assign off      = aluResultM[15:2];

  assign wr_ram   = memWriteM && !mmio_sel;
  assign wr_cycle = memWriteM && mmio_sel && (off == OFF_CYCLE);
  assign wr_tx    = memWriteM && mmio_sel && (off == OFF_TX);
  assign wr_ctrl  = memWriteM && mmio_sel && (off == OFF_CTRL);

  // Byte lane bits never take part in decode.
  assign unused_addr = ^aluResultM[1:0];

  // RAM: no reset so contents survive a core reset.
  logic [WIDTH-1:0] ram_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_ram) ram_q[ram_idx] <= writeData;
  end

  // Cycle counter; a write clears it instead of incrementing.
  logic [31:0] cycle_q;
  logic [31:0] cycle_d;

  assign cycle_d = wr_cycle ? 32'd0 : cycle_q + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_d;
  end

  // TX FIFO
  logic [WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [FW-1:0]    wr_ptr_q;
  logic [FW-1:0]    wr_ptr_d;
  logic [FW-1:0]    rd_ptr_q;
  logic [FW-1:0]    rd_ptr_d;
  logic [FW:0]      cnt_q;
  logic [FW:0]      cnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (FW+1)'(FIFO_DEPTH));
  assign pop   = !empty && outReady;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok = wr_tx && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + FW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + FW'(1);
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + (FW+1)'(1);
      2'b01:   cnt_d = cnt_q - (FW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (wr_ctrl && writeData[0]) ovf_d = 1'b0;
    // Set is evaluated last so it wins over a clear.
    if (wr_tx && full && !pop)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage needs no reset; pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= writeData;
  end

  assign outValid = !empty;
  assign outData  = fifo_q[rd_ptr_q];

  // Load path
  logic [WIDTH-1:0] status;

  always_comb begin
    status           = '0;
    status[0]        = empty;
    status[1]        = full;
    status[2]        = ovf_q;
    status[FW+3:3]   = cnt_q;
  end

  always_comb begin
    readDataM = '0;
    if (!mmio_sel) begin
      readDataM = ram_q[ram_idx];
    end else begin
      unique case (off)
        OFF_CYCLE:  readDataM = WIDTH'(cycle_q);
        OFF_STATUS: readDataM = status;
        default:    readDataM = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: scoreboard bench for data_mem_mmio.
// Expected FIFO words are queued on accepted pushes, compared on pops.
module tb_data_mem_mmio;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT = 32'hFFFF_0004;
  localparam logic [31:0] A_TX   = 32'hFFFF_0008;
  localparam logic [31:0] A_CTRL = 32'hFFFF_000C;
  localparam int          FD     = 4;

  logic        clk;
  logic        reset;
  logic        memWriteM;
  logic [31:0] aluResultM;
  logic [31:0] writeData;
  logic [31:0] readDataM;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady;

  int          nchk;
  int          nerr;
  logic [31:0] exp_q [$];

  data_mem_mmio dut (
    .clk        (clk),
    .reset      (reset),
    .memWriteM  (memWriteM),
    .aluResultM (aluResultM),
    .writeData  (writeData),
    .readDataM  (readDataM),
    .outData    (outData),
    .outValid   (outValid),
    .outReady   (outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; samples at the falling edge and runs the
  // FIFO scoreboard for that cycle.
  task automatic cyc(input logic we, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rdat);
    int          pre;
    bit          popped;
    logic [31:0] e;
    memWriteM  = we;
    aluResultM = a;
    writeData  = d;
    @(negedge clk);
    rdat   = readDataM;
    pre    = exp_q.size();
    popped = 0;
    nchk++;
    if (outValid !== (pre != 0)) begin
      nerr++;
      $display("FAIL outValid got %0b want %0b", outValid, pre != 0);
    end
    if (outValid === 1'b1 && outReady && pre != 0) begin
      popped = 1;
      e = exp_q.pop_front();
      nchk++;
      if (outData !== e) begin
        nerr++;
        $display("FAIL outData got %h want %h", outData, e);
      end
    end
    if (!reset && we && a[31:16] == 16'hFFFF && a[15:2] == 14'd2
        && (pre < FD || popped))
      exp_q.push_back(d);
    @(posedge clk);
    #1;
    memWriteM = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    cyc(1'b0, a, 32'h0, v);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    cyc(1'b1, a, d, v);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      rd(A_CYC, v);
      nchk++;
      if (v !== 32'd0) begin
        nerr++;
        $display("FAIL reset_cycle got %h want 0", v);
      end
    end
    rd(A_STAT, v);
    nchk++;
    if (v !== 32'h1) begin
      nerr++;
      $display("FAIL reset_status got %h want 1", v);
    end
  endtask

  task automatic test_cycle();
    logic [31:0] v;
    reset = 1'b0;
    rd(A_CYC, v);
    nchk++;
    if (v !== 32'd0) begin
      nerr++;
      $display("FAIL cycle_release got %h want 0", v);
    end
    for (int i = 0; i < 9; i++) rd(32'h0, v);
    rd(A_CYC, v);
    nchk++;
    if (v !== 32'd10) begin
      nerr++;
      $display("FAIL cycle_10 got %h want a", v);
    end
    wr(A_CYC, 32'h1234_5678);
    rd(A_CYC, v);
    nchk++;
    if (v !== 32'd0) begin
      nerr++;
      $display("FAIL cycle_clear got %h want 0", v);
    end
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    rd(A_CYC, v);
    nchk++;
    if (v !== 32'hFFFF_FFFF) begin
      nerr++;
      $display("FAIL cycle_max got %h want ffffffff", v);
    end
    rd(A_CYC, v);
    nchk++;
    if (v !== 32'd0) begin
      nerr++;
      $display("FAIL cycle_wrap got %h want 0", v);
    end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] mram [64];
    bit          mv [64];
    logic [31:0] aa [3];
    aa[0] = 32'h10;
    aa[1] = 32'h13;
    aa[2] = 32'h110;
    for (int i = 0; i < 64; i++) mv[i] = 0;
    wr(32'h10, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      rd(aa[i], v);
      nchk++;
      if (v !== 32'hDEAD_BEEF) begin
        nerr++;
        $display("FAIL ram_alias addr %h got %h want deadbeef", aa[i], v);
      end
    end
    cyc(1'b1, 32'h10, 32'h1234_5678, v);
    nchk++;
    if (v !== 32'hDEAD_BEEF) begin
      nerr++;
      $display("FAIL ram_same_cycle got %h want deadbeef", v);
    end
    mram[4] = 32'h1234_5678;
    mv[4]   = 1;
    for (int i = 0; i < 8; i++) begin
      a = 32'($urandom_range(0, 1023));
      d = $urandom;
      wr(a, d);
      mram[a[7:2]] = d;
      mv[a[7:2]]   = 1;
    end
    wr(32'hFFFF_0010, 32'hCAFE_F00D);
    for (int i = 0; i < 64; i++) begin
      if (mv[i]) begin
        a = (32'($urandom_range(0, 3)) << 8) | (32'(i) << 2)
            | 32'($urandom_range(0, 3));
        rd(a, v);
        nchk++;
        if (v !== mram[i]) begin
          nerr++;
          $display("FAIL ram_rand addr %h got %h want %h", a, v, mram[i]);
        end
      end
    end
    aa[0] = 32'hFFFF_0010;
    aa[1] = A_TX;
    aa[2] = A_CTRL;
    for (int i = 0; i < 3; i++) begin
      rd(aa[i], v);
      nchk++;
      if (v !== 32'h0) begin
        nerr++;
        $display("FAIL mmio_zero addr %h got %h want 0", aa[i], v);
      end
    end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] v;
    outReady = 1'b0;
    for (int i = 1; i <= 4; i++) wr(A_TX, 32'(i));
    rd(A_STAT, v);
    nchk++;
    if (v !== 32'h22) begin
      nerr++;
      $display("FAIL fifo_full got %h want 22", v);
    end
    wr(A_TX, 32'd5);
    rd(A_STAT, v);
    nchk++;
    if (v !== 32'h26) begin
      nerr++;
      $display("FAIL fifo_ovf got %h want 26", v);
    end
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) rd(32'h0, v);
    rd(A_STAT, v);
    nchk++;
    if (v !== 32'h05) begin
      nerr++;
      $display("FAIL fifo_drained got %h want 5", v);
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] v;
    logic [31:0] cd [3];
    logic [31:0] ex [3];
    cd[0] = 32'h0; ex[0] = 32'h05;
    cd[1] = 32'h1; ex[1] = 32'h01;
    cd[2] = 32'h0; ex[2] = 32'h01;
    for (int i = 0; i < 3; i++) begin
      wr(A_CTRL, cd[i]);
      rd(A_STAT, v);
      nchk++;
      if (v !== ex[i]) begin
        nerr++;
        $display("FAIL ctrl_%0d got %h want %h", i, v, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    outReady = 1'b0;
    for (int i = 1; i <= 4; i++) wr(A_TX, 32'h10 + 32'(i));
    outReady = 1'b1;
    wr(A_TX, 32'd9);
    rd(A_STAT, v);
    nchk++;
    if (v !== 32'h22) begin
      nerr++;
      $display("FAIL b2b_status got %h want 22", v);
    end
    for (int i = 0; i < 6; i++) rd(32'h0, v);
    rd(A_STAT, v);
    nchk++;
    if (v !== 32'h01) begin
      nerr++;
      $display("FAIL b2b_drained got %h want 1", v);
    end
  endtask

  task automatic test_partial();
    logic [31:0] v;
    outReady = 1'b1;
    wr(A_TX, 32'd7);
    wr(A_TX, 32'd8);
    rd(A_STAT, v);
    nchk++;
    if (v !== 32'h08) begin
      nerr++;
      $display("FAIL partial_count got %h want 8", v);
    end
    rd(A_STAT, v);
    nchk++;
    if (v !== 32'h01) begin
      nerr++;
      $display("FAIL partial_empty got %h want 1", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    outReady = 1'b0;
    wr(32'h40, 32'hA5A5_0001);
    wr(A_TX, 32'h31);
    wr(A_TX, 32'h32);
    rd(A_STAT, v);
    nchk++;
    if (v !== 32'h10) begin
      nerr++;
      $display("FAIL pre_reset_status got %h want 10", v);
    end
    memWriteM  = 1'b1;
    aluResultM = A_TX;
    writeData  = 32'h33;
    reset      = 1'b1;
    #1;
    exp_q.delete();
    nchk++;
    if (outValid !== 1'b0) begin
      nerr++;
      $display("FAIL async_reset outValid got %b want 0", outValid);
    end
    @(posedge clk);
    #1;
    memWriteM = 1'b0;
    reset     = 1'b0;
    outReady  = 1'b1;
    rd(A_STAT, v);
    nchk++;
    if (v !== 32'h01) begin
      nerr++;
      $display("FAIL post_reset_status got %h want 1", v);
    end
    rd(32'h40, v);
    nchk++;
    if (v !== 32'hA5A5_0001) begin
      nerr++;
      $display("FAIL ram_kept got %h want a5a50001", v);
    end
    rd(32'h0, v);
  endtask

  initial begin
    nchk       = 0;
    nerr       = 0;
    reset      = 1'b1;
    memWriteM  = 1'b0;
    aluResultM = '0;
    writeData  = '0;
    outReady   = 1'b0;
    test_reset();
    test_cycle();
    test_ram();
    test_fifo_overflow();
    test_ctrl();
    test_back_to_back();
    test_partial();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
